pattern_serializer: RTL and testbench
=====================================

Name: pattern_serializer

Overview:
- Serial pattern transmitter; the source end of the single-bit stream consumed by the team's 1101 Mealy sequence detector.
- Captures a PAT_W-bit pattern, a repeat count and an inter-repeat gap length on a start pulse.
- Shifts the pattern out MSB first, once per clock, for the requested number of repetitions, then pulses done.
- Drives the detector in system benches and on-chip self-test paths.

Parameters:
- PAT_W, 4, pattern width in bits; must be >= 2.
- CNT_W, 8, width of the repeat count.
- GAP_W, 4, width of the gap length.
- IDLE_BIT, 1'b0, value driven on out whenever out_valid=0.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- pattern  in  PAT_W  bits to send, MSB first; captured when start is accepted.
- repeat_cnt  in  CNT_W  number of pattern repetitions; captured when start is accepted.
- gap  in  GAP_W  idle cycles between repetitions; captured when start is accepted.
- abort  in  1  synchronous cancel of the current transfer.
- out  out  1  serial data bit.
- out_valid  out  1  high when out carries a pattern bit.
- busy  out  1  high while a transfer is in progress.
- done  out  1  one-cycle pulse at normal completion.

Behaviour:
- Reset at an edge with rst=1: state=IDLE, out=IDLE_BIT, out_valid=0, busy=0, done=0, all internal counters cleared. rst overrides every other input, including mid-transfer.
- All outputs are registered.
- States: IDLE, SHIFT, GAP, DONE.
- IDLE, start=1, repeat_cnt!=0:
  - Capture pattern, repeat_cnt and gap; go to SHIFT.
  - Latency 1: in the next cycle out=pattern[PAT_W-1], out_valid=1, busy=1.
- IDLE, start=1, repeat_cnt==0:
  - Go to DONE. Next cycle done=1, out_valid=0, busy=0. No bits are sent.
- SHIFT:
  - One bit per cycle, MSB to LSB; out_valid=1; the bit index decrements each cycle.
  - After the LSB cycle, if repetitions remain and gap!=0: go to GAP.
  - After the LSB cycle, if repetitions remain and gap==0: restart at the MSB the next cycle, with no bubble.
  - After the LSB cycle of the last repetition: go to DONE.
- GAP:
  - Exactly gap cycles with out=IDLE_BIT, out_valid=0, busy=1.
  - Then SHIFT, MSB of the next repetition.
- DONE:
  - One cycle with done=1, busy=0, out_valid=0. Then IDLE.
  - start is ignored in this cycle.
- Timing from the acceptance edge, with R=repeat_cnt and G=gap:
  - First bit in cycle 1.
  - Last bit in cycle R*PAT_W + (R-1)*G.
  - done in the following cycle.
- start while busy=1 or in DONE: ignored; the captured registers are unchanged.
- Changes on pattern, repeat_cnt or gap after capture have no effect on the transfer.
- abort=1 in SHIFT or GAP:
  - Next cycle state=IDLE, out_valid=0, out=IDLE_BIT, busy=0. No done pulse.
  - abort in IDLE or DONE has no effect.
  - abort and start asserted together in IDLE: start wins.
- Counters:
  - Repeat counter is CNT_W wide and decrements once per completed repetition.
  - repeat_cnt = 2^CNT_W-1 is sent in full; the counter never wraps.
  - Bit index is clog2(PAT_W) bits; gap counter is GAP_W bits.

Decomposition:
- Package seqgen_pkg holds the state enum (IDLE, SHIFT, GAP, DONE) and the default widths PAT_W, CNT_W and GAP_W.
- One sub-module, pattern_shreg, holds the PAT_W-bit loadable shift register. It has load, shift and msb ports.
- The FSM and all counters stay in pattern_serializer.

Test Plan:
- Reset release, no start: out=0, out_valid=0, busy=0, done=0 held for 10 cycles.
- pattern=4'b1101, repeat_cnt=2, gap=2 → out_valid bits 1,1,0,1 in cycles 1–4; cycles 5–6 out_valid=0, out=0; bits 1,1,0,1 in cycles 7–10; done=1 in cycle 11 only. A 1101 detector placed downstream outputs out=1 twice.
- pattern=4'b1011, repeat_cnt=3, gap=0 → 12 contiguous valid bits 101110111011; done in cycle 13; busy=1 in cycles 1–12.
- repeat_cnt=0 with start → done=1 in cycle 1, out_valid never asserted.
- abort in cycle 3 of a repeat_cnt=2 transfer → out_valid=0 and busy=0 from cycle 4, done never pulses. A start pulsed while busy earlier is ignored; a new start in IDLE works normally.
- rst=1 in cycle 2 of a transfer → all outputs at reset values from the next cycle; a new start after rst falls yields a full sequence from the MSB.

Source files
------------

// File: rtl/seqgen_pkg.sv
// seqgen_pkg: shared state encoding and default widths for the pattern serializer.
package seqgen_pkg;
  localparam int PAT_W = 4;
  localparam int CNT_W = 8;
  localparam int GAP_W = 4;
  typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_e;
endpackage

// File: rtl/pattern_shreg.sv
// pattern_shreg: loadable left shift register, msb out, fills with FILL.
module pattern_shreg #(
  parameter int   W    = 4,
  parameter logic FILL = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] d,
  output logic         msb
);
  logic [W-1:0] reg_q, reg_d;
  always_comb reg_d = load ? d : shift ? {reg_q[W-2:0], FILL} : reg_q;
  always_ff @(posedge clk) begin
    if (rst) reg_q <= {W{FILL}};
    else     reg_q <= reg_d;
  end
  assign msb = reg_q[W-1];
endmodule

// File: rtl/pattern_serializer.sv
// pattern_serializer: sends a captured pattern MSB first, repeat_cnt times with gap idle cycles between.
module pattern_serializer
  import seqgen_pkg::*;
#(
  parameter int   PAT_W    = seqgen_pkg::PAT_W,
  parameter int   CNT_W    = seqgen_pkg::CNT_W,
  parameter int   GAP_W    = seqgen_pkg::GAP_W,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic [GAP_W-1:0] gap,
  input  logic             abort,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);
  localparam int IDX_W = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);
  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [GAP_W-1:0] gap_len_q, gap_len_d, gap_cnt_q, gap_cnt_d;
  logic [PAT_W-1:0] pat_q, pat_d, ld_val;
  logic             valid_q, valid_d, busy_q, busy_d, done_q, done_d, load, shift;
  // The shifter drains to IDLE_BIT after the LSB, so its msb doubles as the registered out.
  pattern_shreg #(.W(PAT_W), .FILL(IDLE_BIT)) u_shreg (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift),
    .d     (ld_val),
    .msb   (out)
  );
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rep_d     = rep_q;
    gap_len_d = gap_len_q;
    gap_cnt_d = gap_cnt_q;
    pat_d     = pat_q;
    ld_val    = pat_q;
    load      = 1'b0;
    shift     = 1'b0;
    valid_d   = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        if (repeat_cnt != '0) begin
          pat_d     = pattern;
          rep_d     = repeat_cnt;
          gap_len_d = gap;
          idx_d     = IDX_TOP;
          ld_val    = pattern;
          load      = 1'b1;
          state_d   = SHIFT;
          valid_d   = 1'b1;
          busy_d    = 1'b1;
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      SHIFT: if (abort) begin
        state_d = IDLE;
        ld_val  = {PAT_W{IDLE_BIT}};
        load    = 1'b1;
      end else if (idx_q != '0) begin
        idx_d   = idx_q - IDX_W'(1);
        shift   = 1'b1;
        valid_d = 1'b1;
        busy_d  = 1'b1;
      end else if (rep_q == CNT_W'(1)) begin
        state_d = DONE;
        shift   = 1'b1;
        done_d  = 1'b1;
      end else begin
        rep_d  = rep_q - CNT_W'(1);
        busy_d = 1'b1;
        if (gap_len_q == '0) begin
          idx_d   = IDX_TOP;
          load    = 1'b1;
          valid_d = 1'b1;
        end else begin
          state_d   = GAP;
          gap_cnt_d = gap_len_q - GAP_W'(1);
          shift     = 1'b1;
        end
      end
      GAP: if (abort) begin
        state_d = IDLE;
      end else if (gap_cnt_q == '0) begin
        state_d = SHIFT;
        idx_d   = IDX_TOP;
        load    = 1'b1;
        valid_d = 1'b1;
        busy_d  = 1'b1;
      end else begin
        gap_cnt_d = gap_cnt_q - GAP_W'(1);
        busy_d    = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      rep_q     <= '0;
      gap_len_q <= '0;
      gap_cnt_q <= '0;
      pat_q     <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rep_q     <= rep_d;
      gap_len_q <= gap_len_d;
      gap_cnt_q <= gap_cnt_d;
      pat_q     <= pat_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
endmodule

// File: tb/tb_pattern_serializer.sv
// tb_pattern_serializer: directed vectors; each cycle compares {out,out_valid,busy,done} as one nibble.
module tb_pattern_serializer;
  logic       clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic [3:0] pattern = '0;
  logic [7:0] repeat_cnt = '0;
  logic [3:0] gap = '0;
  logic       out, out_valid, busy, done;
  int         vectors = 0, miscompares = 0, det = 0;
  logic [3:0] hist = '0;
  pattern_serializer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pattern    (pattern),
    .repeat_cnt (repeat_cnt),
    .gap        (gap),
    .abort      (abort),
    .out        (out),
    .out_valid  (out_valid),
    .busy       (busy),
    .done       (done)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Advance one clock, sample just after the edge and feed a 1101 detector model.
  task automatic tick();
    @(posedge clk);
    #1;
    if (out_valid) begin
      hist = {hist[2:0], out};
      if (hist == 4'b1101) det++;
    end
  endtask
  task automatic step(input string tag, input logic [3:0] exp);
    tick();
    check(tag, {60'd0, out, out_valid, busy, done}, {60'd0, exp});
  endtask
  task automatic go(input logic [3:0] p, input logic [7:0] r, input logic [3:0] g);
    pattern    = p;
    repeat_cnt = r;
    gap        = g;
    start      = 1'b1;
  endtask
  // Cycle i (1..n) expects nibble i counted from the left of the n-nibble vector.
  task automatic run(input string tag, input int n, input logic [63:0] exp);
    for (int i = 1; i <= n; i++) begin
      step($sformatf("%s c%0d", tag, i), exp[4*(n-i) +: 4]);
      if (i == 1) begin
        start      = 1'b0;
        abort      = 1'b0;
        pattern    = ~pattern;
        repeat_cnt = 8'd9;
        gap        = 4'd7;
      end
    end
  endtask
  initial begin
    int nv, n1;
    tick();
    tick();
    check("reset", {60'd0, out, out_valid, busy, done}, 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) step($sformatf("idle %0d", i), 4'h0);
    det = 0;
    hist = '0;
    go(4'b1101, 8'd2, 4'd2);
    run("r2g2", 12, 48'hEE6E22EE6E10);
    check("detector hits", 64'(det), 64'd2);
    go(4'b1011, 8'd3, 4'd0);
    run("r3g0", 14, 56'hE6EEE6EEE6EE10);
    go(4'b1111, 8'd0, 4'd3);
    run("r0", 2, 8'h10);
    go(4'b1001, 8'd2, 4'd1);
    step("abort c1", 4'hE);
    start = 1'b0;
    pattern = 4'b0000;
    repeat_cnt = 8'd0;
    start = 1'b1;
    step("abort c2 start ignored", 4'h6);
    start = 1'b0;
    step("abort c3", 4'h6);
    abort = 1'b1;
    step("abort c4", 4'h0);
    abort = 1'b0;
    for (int i = 0; i < 4; i++) step($sformatf("after abort %0d", i), 4'h0);
    abort = 1'b1;
    go(4'b0110, 8'd1, 4'd0);
    run("start beats abort", 6, 24'h6EE610);
    go(4'b1101, 8'd1, 4'd0);
    step("rst c1", 4'hE);
    start = 1'b0;
    step("rst c2", 4'hE);
    rst = 1'b1;
    step("rst c3", 4'h0);
    rst = 1'b0;
    go(4'b1011, 8'd1, 4'd0);
    run("after rst", 6, 24'hE6EE10);
    nv = 0;
    n1 = 0;
    go(4'b1000, 8'd255, 4'd0);
    for (int i = 1; i <= 1021; i++) begin
      tick();
      if (i == 1) start = 1'b0;
      if (out_valid) nv++;
      if (out) n1++;
      if (i == 1020) check("max last bit", {60'd0, out, out_valid, busy, done}, 64'h6);
      if (i == 1021) check("max done", {60'd0, out, out_valid, busy, done}, 64'h1);
    end
    check("max valid count", 64'(nv), 64'd1020);
    check("max ones count", 64'(n1), 64'd255);
    step("max idle", 4'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
